// File: rtl/uart_rx_word_if.sv
// Word handshake between the UART receiver and its consumer.
// The receiver drives data/valid as master; the consumer answers with ready.
`timescale 1ns/1ps

interface uart_rx_word_if;
   logic [31:0] rx_data;
   logic        rx_valid;
   logic        rx_ready;

   modport master (
      output rx_data,
      output rx_valid,
      input  rx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      output rx_ready
   );
endinterface

// File: rtl/uart_rx_word.sv
// 8N1 UART receiver that packs four LSB-first bytes into a 32-bit word.
// The first received byte lands in bits [7:0]; framing errors and overruns are 1-cycle pulses.
`timescale 1ns/1ps

module uart_rx_word #(
   parameter int CLK_FREQ = 10000000,
   parameter int BAUD     = 9600
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          rx,
   uart_rx_word_if.master rx_if,
   output logic          frame_err,
   output logic          overrun
);

   localparam int CPB = CLK_FREQ / BAUD;
   localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
   localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(CPB - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   logic          rx_meta_q;
   logic          rs_q;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [1:0]    idx_q, idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [31:0]   word_q, word_d;
   logic [31:0]   data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          ovr_q, ovr_d;
   logic          word_done;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      idx_d     = idx_q;
      shreg_d   = shreg_q;
      word_d    = word_q;
      data_d    = data_q;
      valid_d   = valid_q;
      ferr_d    = 1'b0;
      ovr_d     = 1'b0;
      word_done = 1'b0;

      if (valid_q && rx_if.rx_ready) begin
         valid_d = 1'b0;
      end

      // Disabling drops any partial word but leaves a pending output word alone.
      if (!en) begin
         state_d = IDLE;
         cnt_d   = '0;
         bit_d   = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_d = '0;
               bit_d = '0;
               if (!rs_q) begin
                  state_d = START;
               end
            end

            START: begin
               if (cnt_q == HALF) begin
                  cnt_d   = '0;
                  state_d = rs_q ? IDLE : DATA;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end

            DATA: begin
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  shreg_d = {rs_q, shreg_q[7:1]};
                  if (bit_q == 3'd7) begin
                     bit_d   = '0;
                     state_d = STOP;
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end

            // A low stop bit discards the whole partial word, not just this byte.
            STOP: begin
               if (cnt_q == LAST) begin
                  cnt_d = '0;
                  if (rs_q) begin
                     word_d[{idx_q, 3'b000} +: 8] = shreg_q;
                     idx_d     = idx_q + 2'd1;
                     word_done = (idx_q == 2'd3);
                     state_d   = IDLE;
                  end else begin
                     ferr_d  = 1'b1;
                     idx_d   = '0;
                     state_d = BREAK;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end

            BREAK: begin
               cnt_d = '0;
               if (rs_q) begin
                  state_d = IDLE;
               end
            end

            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      if (word_done) begin
         if (!valid_q || rx_if.rx_ready) begin
            data_d  = word_d;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rs_q      <= 1'b1;
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         idx_q     <= '0;
         shreg_q   <= '0;
         word_q    <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rs_q      <= rx_meta_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         idx_q     <= idx_d;
         shreg_q   <= shreg_d;
         word_q    <= word_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
      end
   end

   assign rx_if.rx_data  = data_q;
   assign rx_if.rx_valid = valid_q;
   assign frame_err      = ferr_q;
   assign overrun        = ovr_q;

endmodule

// File: tb/tb_uart_rx_word.sv
// Bench for uart_rx_word: table of words plus hand-written error, overrun and reset sequences.
// Expected words go into a queue when sent and are popped when the handshake completes.
`timescale 1ns/1ps

module tb_uart_rx_word;

   localparam int CLK_FREQ = 160;
   localparam int BAUD     = 10;
   localparam int CPB      = 16;

   logic clk = 1'b0;
   logic rst;
   logic en;
   logic rx;
   logic frame_err;
   logic overrun;

   uart_rx_word_if busIf ();

   uart_rx_word #(
      .CLK_FREQ(CLK_FREQ),
      .BAUD    (BAUD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .rx       (rx),
      .rx_if    (busIf.master),
      .frame_err(frame_err),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [7:0]  b2;
      logic [7:0]  b3;
      logic [31:0] expWord;
   } vec_t;

   vec_t        vecs[6];
   logic [31:0] expQ[$];
   int          checksTotal = 0;
   int          checksPassed = 0;
   int          ferrCount = 0;
   int          ovrCount = 0;
   int          wordCount = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checksTotal++;
      if (actual === required) begin
         checksPassed++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
      end
   endtask

   // Inputs change #1 after posedge, so negedge sees a settled handshake.
   always @(negedge clk) begin
      if (!rst) begin
         if (frame_err) ferrCount++;
         if (overrun) ovrCount++;
         if (busIf.rx_valid && busIf.rx_ready) begin
            wordCount++;
            if (expQ.size() == 0) begin
               checksTotal++;
               $display("[TB] FAIL unexpected word: got %h, expected none", busIf.rx_data);
            end else begin
               checkOutput("word", busIf.rx_data, expQ.pop_front());
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic sendBit(input logic v);
      rx = v;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic idleGap(input int n);
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sendByte(input logic [7:0] b, input logic stopBit);
      sendBit(1'b0);
      for (int i = 0; i < 8; i++) sendBit(b[i]);
      sendBit(stopBit);
      idleGap(4);
   endtask

   task automatic applyStimulus(input vec_t v, input bit expectWord);
      if (expectWord) expQ.push_back(v.expWord);
      sendByte(v.b0, 1'b1);
      sendByte(v.b1, 1'b1);
      sendByte(v.b2, 1'b1);
      sendByte(v.b3, 1'b1);
   endtask

   task automatic waitDrain(input string name);
      for (int i = 0; i < 300 && expQ.size() != 0; i++) @(posedge clk);
      #1;
      checkOutput(name, 32'(expQ.size()), 32'd0);
   endtask

   initial begin
      int f0;
      int o0;
      int w0;

      vecs[0] = '{8'h78, 8'h56, 8'h34, 8'h12, 32'h12345678};
      vecs[1] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h44332211};
      vecs[2] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201};
      vecs[3] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hEFBEADDE};
      vecs[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 32'hD4C3B2A1};
      vecs[5] = '{8'h0F, 8'h1E, 8'h2D, 8'h3C, 32'h3C2D1E0F};

      rst = 1'b1;
      en  = 1'b0;
      rx  = 1'b1;
      busIf.rx_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset rx_data", busIf.rx_data, 32'h0);
      checkOutput("reset rx_valid", 32'(busIf.rx_valid), 32'd0);
      checkOutput("reset frame_err", 32'(frame_err), 32'd0);
      checkOutput("reset overrun", 32'(overrun), 32'd0);
      rst = 1'b0;
      en  = 1'b1;
      busIf.rx_ready = 1'b1;
      idleGap(4);

      for (int i = 0; i < 4; i++) begin
         f0 = ferrCount;
         w0 = wordCount;
         applyStimulus(vecs[i], 1'b1);
         waitDrain("table word drained");
         idleGap(4);
         checkOutput("table one valid pulse", 32'(wordCount - w0), 32'd1);
         checkOutput("table no frame_err", 32'(ferrCount - f0), 32'd0);
      end

      f0 = ferrCount;
      w0 = wordCount;
      rx = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      idleGap(40);
      checkOutput("glitch no frame_err", 32'(ferrCount - f0), 32'd0);
      checkOutput("glitch no word", 32'(wordCount - w0), 32'd0);
      checkOutput("glitch rx_valid", 32'(busIf.rx_valid), 32'd0);

      f0 = ferrCount;
      sendByte(8'hA5, 1'b0);
      idleGap(20);
      checkOutput("bad stop frame_err", 32'(ferrCount - f0), 32'd1);
      applyStimulus(vecs[1], 1'b1);
      waitDrain("after frame_err drained");
      checkOutput("after frame_err no more errors", 32'(ferrCount - f0), 32'd1);

      o0 = ovrCount;
      busIf.rx_ready = 1'b0;
      applyStimulus(vecs[4], 1'b1);
      applyStimulus(vecs[5], 1'b0);
      idleGap(4);
      checkOutput("overrun pulse", 32'(ovrCount - o0), 32'd1);
      checkOutput("overrun valid held", 32'(busIf.rx_valid), 32'd1);
      checkOutput("overrun data held", busIf.rx_data, 32'hD4C3B2A1);
      busIf.rx_ready = 1'b1;
      waitDrain("overrun W1 drained");
      idleGap(3);
      checkOutput("overrun valid cleared", 32'(busIf.rx_valid), 32'd0);

      f0 = ferrCount;
      sendByte(vecs[3].b0, 1'b1);
      sendByte(vecs[3].b1, 1'b1);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("mid reset rx_data", busIf.rx_data, 32'h0);
      checkOutput("mid reset rx_valid", 32'(busIf.rx_valid), 32'd0);
      rst = 1'b0;
      idleGap(4);
      applyStimulus(vecs[2], 1'b1);
      waitDrain("after reset drained");
      checkOutput("after reset no frame_err", 32'(ferrCount - f0), 32'd0);

      f0 = ferrCount;
      rx = 1'b0;
      repeat (40 * CPB) @(posedge clk);
      #1;
      idleGap(2 * CPB);
      checkOutput("break one frame_err", 32'(ferrCount - f0), 32'd1);
      applyStimulus(vecs[0], 1'b1);
      waitDrain("after break drained");
      checkOutput("after break single frame_err", 32'(ferrCount - f0), 32'd1);

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
